// File: rtl/p251_mul_arbiter_if.sv
// Request/result bus of the shared GF(251) multiplier.
// The master side is the requesters plus the result consumer; the slave side is the arbiter.
interface p251_mul_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4,
  parameter int ID_W  = 3
);
  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ-1:0]       o_req_ready;
  logic [8*N_REQ-1:0]     i_req_a;
  logic [8*N_REQ-1:0]     i_req_b;
  logic [TAG_W*N_REQ-1:0] i_req_tag;
  logic                   o_res_valid;
  logic                   i_res_ready;
  logic [7:0]             o_res_c;
  logic [ID_W-1:0]        o_res_id;
  logic [TAG_W-1:0]       o_res_tag;
  logic                   o_busy;

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_tag, i_res_ready,
    input  o_req_ready, o_res_valid, o_res_c, o_res_id, o_res_tag, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_tag, i_res_ready,
    output o_req_ready, o_res_valid, o_res_c, o_res_id, o_res_tag, o_busy
  );
endinterface

// File: rtl/p251_mul_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier + mod-251 reducer between N_REQ requesters.
// Three pipeline stages (operands, product, reduced result), globally stalled by result backpressure.

module p251_mul_red (
  input  logic        i_start,
  input  logic [15:0] i_x,
  output logic [7:0]  o_c
);
  // 256 == 5 (mod 251): fold the high byte twice, then one conditional subtract.
  logic [10:0] fold1;
  logic [8:0]  fold2;
  logic [8:0]  fold3;

  always_comb begin
    fold1 = 11'(i_x[15:8]) * 11'd5 + 11'(i_x[7:0]);
    fold2 = 9'(fold1[10:8]) * 9'd5 + 9'(fold1[7:0]);
    fold3 = (fold2 >= 9'd251) ? (fold2 - 9'd251) : fold2;
    o_c   = i_start ? 8'(fold3) : 8'd0;
  end
endmodule

module p251_mul_arbiter #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4,
  parameter int ID_W  = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  p251_mul_arbiter_if.slave  bus
);
  localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

  logic [7:0]       a_arr   [N_REQ];
  logic [7:0]       b_arr   [N_REQ];
  logic [TAG_W-1:0] tag_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi]   = bus.i_req_a[gi*8 +: 8];
    assign b_arr[gi]   = bus.i_req_b[gi*8 +: 8];
    assign tag_arr[gi] = bus.i_req_tag[gi*TAG_W +: TAG_W];
  end

  logic [ID_W-1:0]  ptr_reg;
  logic             s1_valid_reg, s2_valid_reg, res_valid_reg;
  logic [7:0]       s1_a_reg, s1_b_reg;
  logic [ID_W-1:0]  s1_id_reg, s2_id_reg, res_id_reg;
  logic [TAG_W-1:0] s1_tag_reg, s2_tag_reg, res_tag_reg;
  logic [15:0]      s2_prod_reg;
  logic [7:0]       res_c_reg;
  logic [7:0]       red_c;

  logic             adv;
  logic [ID_W:0]    start_idx, pos, idx;
  logic [N_REQ-1:0] rot, grant_raw, req_ready;
  logic             found, accept;
  logic [7:0]       sel_a, sel_b;
  logic [TAG_W-1:0] sel_tag;

  assign adv = !res_valid_reg | bus.i_res_ready;

  // Rotate the valids so the search always starts at bit 0, then map the winner back.
  always_comb begin
    start_idx = {1'b0, ptr_reg} + (ID_W+1)'(1);
    if (start_idx >= N_REQ_W) start_idx = '0;
    rot   = N_REQ'({bus.i_req_valid, bus.i_req_valid} >> start_idx);
    pos   = '0;
    found = 1'b0;
    for (int p = N_REQ - 1; p >= 0; p--) begin
      if (rot[p]) begin
        pos   = (ID_W+1)'(p);
        found = 1'b1;
      end
    end
    idx = start_idx + pos;
    if (idx >= N_REQ_W) idx = idx - N_REQ_W;

    grant_raw = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_tag   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      grant_raw[j] = found && (idx == (ID_W+1)'(j));
      if (grant_raw[j]) begin
        sel_a   = a_arr[j];
        sel_b   = b_arr[j];
        sel_tag = tag_arr[j];
      end
    end
    req_ready = grant_raw & {N_REQ{adv & !i_rst}};
    accept    = |req_ready;
  end

  p251_mul_red u_red (
    .i_start (s2_valid_reg),
    .i_x     (s2_prod_reg),
    .o_c     (red_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_reg       <= ID_W'(N_REQ - 1);
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_id_reg     <= '0;
      s1_tag_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_prod_reg   <= '0;
      s2_id_reg     <= '0;
      s2_tag_reg    <= '0;
      res_valid_reg <= 1'b0;
      res_c_reg     <= '0;
      res_id_reg    <= '0;
      res_tag_reg   <= '0;
    end else if (adv) begin
      if (accept) ptr_reg <= ID_W'(idx);
      s1_valid_reg  <= accept;
      s1_a_reg      <= sel_a;
      s1_b_reg      <= sel_b;
      s1_id_reg     <= ID_W'(idx);
      s1_tag_reg    <= sel_tag;
      s2_valid_reg  <= s1_valid_reg;
      s2_prod_reg   <= 16'(s1_a_reg) * 16'(s1_b_reg);
      s2_id_reg     <= s1_id_reg;
      s2_tag_reg    <= s1_tag_reg;
      res_valid_reg <= s2_valid_reg;
      res_c_reg     <= red_c;
      res_id_reg    <= s2_id_reg;
      res_tag_reg   <= s2_tag_reg;
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_res_valid = res_valid_reg;
  assign bus.o_res_c     = res_c_reg;
  assign bus.o_res_id    = res_id_reg;
  assign bus.o_res_tag   = res_tag_reg;
  assign bus.o_busy      = s1_valid_reg | s2_valid_reg | res_valid_reg;

  // Operands above 250 give an undefined residue; flag them in simulation.
  a_canonical: assert property (@(posedge i_clk) disable iff (i_rst)
    accept |-> (sel_a <= 8'd250 && sel_b <= 8'd250));
endmodule

// File: tb/tb_p251_mul_arbiter.sv
// Directed bench for p251_mul_arbiter: reset, latency, corners, round-robin, backpressure,
// reset mid-flight and a random phase scored against per-requester expected queues.
module tb_p251_mul_arbiter;
  localparam int N_REQ = 2;
  localparam int TAG_W = 4;
  localparam int ID_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  p251_mul_arbiter_if #(.N_REQ(N_REQ), .TAG_W(TAG_W), .ID_W(ID_W)) bus ();

  p251_mul_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic v, input int a, input int b, input int t);
    bus.i_req_valid[r]             = v;
    bus.i_req_a[r*8 +: 8]          = 8'(a);
    bus.i_req_b[r*8 +: 8]          = 8'(b);
    bus.i_req_tag[r*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  // Scoreboard: record every handshake, match every consumed result per requester.
  logic [11:0] sb_exp;
  logic [11:0] sb_obs;
  always @(negedge clk) begin
    if (!rst) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (bus.i_req_valid[r] && bus.o_req_ready[r]) begin
          sb_exp = {bus.i_req_tag[r*TAG_W +: TAG_W],
                    8'((int'(bus.i_req_a[r*8 +: 8]) * int'(bus.i_req_b[r*8 +: 8])) % 251)};
          if (r == 0) q0.push_back(sb_exp);
          else q1.push_back(sb_exp);
        end
      end
      if (bus.o_res_valid && bus.i_res_ready) begin
        sb_obs = {bus.o_res_tag, bus.o_res_c};
        if (bus.o_res_id == 0 && q0.size() != 0) chk("sb_req0", sb_obs, q0.pop_front());
        else if (bus.o_res_id == 1 && q1.size() != 0) chk("sb_req1", sb_obs, q1.pop_front());
        else chk("sb_unexpected_result_id", bus.o_res_id, 32'hFFFF);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ca[4] = '{250, 128, 0, 1};
  int cb[4] = '{250, 2, 200, 250};
  int ce[4] = '{1, 5, 0, 250};
  logic [1:0] acc;
  int accepted;
  int cyc;
  int jj;

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_req_tag   = '0;
    bus.i_res_ready = 1'b1;

    // Reset state; requests during reset must not be granted
    tick();
    bus.i_req_valid = 2'b11;
    #1;
    chk("reset_req_ready", bus.o_req_ready, 0);
    tick();
    chk("reset_res_valid", bus.o_res_valid, 0);
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_res_c", bus.o_res_c, 0);
    chk("reset_res_id", bus.o_res_id, 0);
    chk("reset_res_tag", bus.o_res_tag, 0);
    bus.i_req_valid = '0;
    rst = 1'b0;
    tick();

    // Single op with latency check: 17*15 = 255 -> 4
    drive(0, 1'b1, 17, 15, 3);
    #1;
    chk("single_ready", bus.o_req_ready, 2'b01);
    tick();
    bus.i_req_valid = '0;
    chk("single_lat1", bus.o_res_valid, 0);
    tick();
    chk("single_lat2", bus.o_res_valid, 0);
    tick();
    chk("single_valid", bus.o_res_valid, 1);
    chk("single_c", bus.o_res_c, 4);
    chk("single_id", bus.o_res_id, 0);
    chk("single_tag", bus.o_res_tag, 3);
    tick();
    chk("single_one_cycle", bus.o_res_valid, 0);
    chk("single_idle", bus.o_busy, 0);

    // Corner operands back-to-back on requester 1
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1, 1'b1, ca[i], cb[i], i + 8);
      else bus.i_req_valid = '0;
      #1;
      if (i < 4) chk("b2b_ready", bus.o_req_ready, 2'b10);
      tick();
      if (i >= 2 && i < 6) begin
        chk("b2b_valid", bus.o_res_valid, 1);
        chk("b2b_c", bus.o_res_c, ce[i-2]);
        chk("b2b_id", bus.o_res_id, 1);
        chk("b2b_tag", bus.o_res_tag, i + 6);
      end else if (i == 6) begin
        chk("b2b_drained", bus.o_res_valid, 0);
      end
    end

    // Contention after reset: grants alternate 0,1,0,1,0,1
    rst = 1'b1;
    q0.delete();
    q1.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        drive(0, 1'b1, 10 + (i + 1) / 2, 3, (i + 1) / 2);
        drive(1, 1'b1, 20 + i / 2, 3, 8 + i / 2);
      end else begin
        bus.i_req_valid = '0;
      end
      #1;
      if (i < 6) chk("rr_grant", bus.o_req_ready, (i % 2 == 0) ? 1 : 2);
      tick();
      if (i >= 2) begin
        jj = i - 2;
        chk("rr_res_valid", bus.o_res_valid, 1);
        chk("rr_res_id", bus.o_res_id, jj % 2);
        chk("rr_res_tag", bus.o_res_tag, (jj % 2) * 8 + jj / 2);
      end
    end

    // Backpressure: 4 ops on req0 (x100), consumer stalls 5 cycles with op0 at the output
    drive(0, 1'b1, 2, 100, 0);
    tick();
    drive(0, 1'b1, 3, 100, 1);
    tick();
    drive(0, 1'b1, 4, 100, 2);
    tick();
    bus.i_res_ready = 1'b0;
    drive(0, 1'b1, 5, 100, 3);
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_ready_low", bus.o_req_ready, 0);
      chk("bp_res_valid", bus.o_res_valid, 1);
      chk("bp_res_c_stable", bus.o_res_c, 200);
      chk("bp_res_tag_stable", bus.o_res_tag, 0);
      chk("bp_busy", bus.o_busy, 1);
      tick();
    end
    bus.i_res_ready = 1'b1;
    #1;
    chk("bp_consume_and_accept", bus.o_req_ready, 2'b01);
    tick();
    bus.i_req_valid = '0;
    chk("bp_res1_c", bus.o_res_c, 49);
    tick();
    chk("bp_res2_c", bus.o_res_c, 149);
    tick();
    chk("bp_res3_c", bus.o_res_c, 249);
    chk("bp_res3_tag", bus.o_res_tag, 3);
    tick();
    chk("bp_drained", bus.o_res_valid, 0);

    // Reset with three ops in flight
    drive(1, 1'b1, 7, 7, 1);
    tick();
    drive(1, 1'b1, 8, 8, 2);
    tick();
    drive(1, 1'b1, 9, 9, 3);
    tick();
    bus.i_req_valid = '0;
    #1;
    chk("rst_flight_busy_before", bus.o_busy, 1);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    tick();
    rst = 1'b0;
    chk("rst_flight_res_valid", bus.o_res_valid, 0);
    chk("rst_flight_busy", bus.o_busy, 0);
    drive(0, 1'b1, 11, 12, 5);
    drive(1, 1'b1, 13, 14, 6);
    #1;
    chk("rst_flight_grant_req0", bus.o_req_ready, 2'b01);
    tick();
    bus.i_req_valid = '0;
    tick();
    tick();
    chk("rst_flight_res_c", bus.o_res_c, 132);
    chk("rst_flight_res_id", bus.o_res_id, 0);
    tick();

    // Random canonical traffic with random valids and consumer stalls
    acc = '0;
    accepted = 0;
    cyc = 0;
    while (accepted < 2000 && cyc < 20000) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (!bus.i_req_valid[r] || acc[r])
          drive(r, ($urandom_range(0, 3) != 0), $urandom_range(0, 250),
                $urandom_range(0, 250), $urandom_range(0, 15));
      end
      bus.i_res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.i_req_valid & bus.o_req_ready;
      chk("rnd_ready_legal",
          ((bus.o_req_ready & ~bus.i_req_valid) == 2'b00) && $onehot0(bus.o_req_ready), 1);
      accepted += $countones(acc);
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("rnd_completed", accepted >= 2000, 1);

    // Drain and confirm every accepted op came back exactly once
    bus.i_req_valid = '0;
    bus.i_res_ready = 1'b1;
    for (int k = 0; k < 20 && bus.o_busy; k++) tick();
    chk("drain_busy", bus.o_busy, 0);
    chk("drain_q0_empty", q0.size(), 0);
    chk("drain_q1_empty", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
